// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states and the
// per-stage control bundle, plus the two canonical bundles.
package pipeline_stall_controller_pkg;

   typedef enum logic [2:0] {
      RUN   = 3'd0,
      DWAIT = 3'd1,
      IWAIT = 3'd2,
      DRAIN = 3'd3,
      HALT  = 3'd4
   } state_t;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_bubble;
      logic ex_mem_write;
      logic mem_wb_write;
   } ctrl_t;

   localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                     id_ex_bubble: 1'b0, ex_mem_write: 1'b1, mem_wb_write: 1'b1};
   localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                     id_ex_bubble: 1'b0, ex_mem_write: 1'b0, mem_wb_write: 1'b0};

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Request/control bundle between the pipeline datapath and the stall sequencer.
// master = pipeline side raising requests, slave = the sequencer.
interface pipeline_stall_controller_if #(
   parameter int CNT_W = 32
);
   logic             hazard_stall;
   logic             branch_taken;
   logic             jump;
   logic             imem_ready;
   logic             dmem_req;
   logic             dmem_ready;
   logic             halt_req;
   logic             pc_write;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_bubble;
   logic             ex_mem_write;
   logic             mem_wb_write;
   logic             halted;
   logic             bus_error;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output hazard_stall, branch_taken, jump, imem_ready, dmem_req, dmem_ready, halt_req,
      input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, mem_wb_write,
      input  halted, bus_error, stall_cycles, flush_count
   );

   modport slave (
      input  hazard_stall, branch_taken, jump, imem_ready, dmem_req, dmem_ready, halt_req,
      output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, mem_wb_write,
      output halted, bus_error, stall_cycles, flush_count
   );
endinterface

// File: rtl/pipeline_stall_controller_sat.sv
// Saturating up-counter used for the stall/flush perf counters; sticks at
// all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer: merges hazard, redirect, memory-wait and halt events
// into one consistent set of per-stage controls, with drain/timeout tracking.
module pipeline_stall_controller
   import pipeline_stall_controller_pkg::*;
#(
   parameter int CNT_W        = 32,
   parameter int DRAIN_CYCLES = 3,
   parameter int WAIT_TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   pipeline_stall_controller_if.slave bus
);

   localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   state_t             state, state_nxt;
   logic [7:0]         wait_cnt, wait_nxt;
   logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
   logic               bus_error_q;
   logic               bus_err_set;
   logic               flush_evt;
   logic               stall_inc;
   logic               flush_inc;
   logic               dmem_stall;
   ctrl_t              ctrl;

   assign dmem_stall = bus.dmem_req && !bus.dmem_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         wait_cnt    <= '0;
         drain_cnt   <= '0;
         bus_error_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_nxt;
         drain_cnt <= drain_nxt;
         if (bus_err_set) begin
            bus_error_q <= 1'b1;
         end
      end
   end

   // RUN and IWAIT share one priority chain: IWAIT simply keeps re-applying
   // the imem-miss rule until fetch data shows up.
   always_comb begin
      state_nxt   = state;
      wait_nxt    = wait_cnt;
      drain_nxt   = drain_cnt;
      bus_err_set = 1'b0;
      flush_evt   = 1'b0;
      ctrl        = CTRL_RUN;
      case (state)
         RUN, IWAIT: begin
            if (dmem_stall) begin
               ctrl      = CTRL_FREEZE;
               wait_nxt  = 8'd1;
               state_nxt = DWAIT;
            end else if (!bus.imem_ready) begin
               ctrl.pc_write    = 1'b0;
               ctrl.if_id_write = 1'b0;
               ctrl.if_id_flush = 1'b1;
               state_nxt        = IWAIT;
            end else if (bus.hazard_stall) begin
               ctrl.pc_write     = 1'b0;
               ctrl.if_id_write  = 1'b0;
               ctrl.id_ex_bubble = 1'b1;
               state_nxt         = RUN;
            end else if (bus.halt_req) begin
               ctrl.pc_write    = 1'b0;
               ctrl.if_id_flush = 1'b1;
               drain_nxt        = DRAIN_W'(DRAIN_CYCLES);
               state_nxt        = DRAIN;
            end else begin
               state_nxt = RUN;
               if (bus.branch_taken || bus.jump) begin
                  ctrl.if_id_flush = 1'b1;
                  flush_evt        = 1'b1;
               end
            end
         end
         DWAIT: begin
            if (bus.dmem_ready) begin
               wait_nxt  = '0;
               state_nxt = RUN;
            end else begin
               ctrl = CTRL_FREEZE;
               if (wait_cnt == 8'(WAIT_TIMEOUT)) begin
                  bus_err_set = 1'b1;
                  state_nxt   = HALT;
               end else begin
                  wait_nxt = wait_cnt + 8'd1;
               end
            end
         end
         DRAIN: begin
            if (dmem_stall) begin
               ctrl = CTRL_FREEZE;
            end else begin
               ctrl.pc_write     = 1'b0;
               ctrl.if_id_flush  = 1'b1;
               ctrl.id_ex_bubble = 1'b1;
               drain_nxt         = drain_cnt - DRAIN_W'(1);
               if (drain_cnt == DRAIN_W'(1)) begin
                  state_nxt = HALT;
               end
            end
         end
         HALT: begin
            ctrl = CTRL_FREEZE;
         end
         default: begin
            ctrl      = CTRL_FREEZE;
            state_nxt = RUN;
         end
      endcase
      if (reset) begin
         ctrl = CTRL_FREEZE;
      end
   end

   // Stall cycles only count fetch-side stalls, not the intentional halt drain.
   assign stall_inc = !reset && !ctrl.pc_write &&
                      ((state == RUN) || (state == IWAIT) || (state == DWAIT));
   assign flush_inc = !reset && flush_evt;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_inc),
      .count (bus.stall_cycles)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush_inc),
      .count (bus.flush_count)
   );

   assign bus.pc_write     = ctrl.pc_write;
   assign bus.if_id_write  = ctrl.if_id_write;
   assign bus.if_id_flush  = ctrl.if_id_flush;
   assign bus.id_ex_bubble = ctrl.id_ex_bubble;
   assign bus.ex_mem_write = ctrl.ex_mem_write;
   assign bus.mem_wb_write = ctrl.mem_wb_write;
   assign bus.halted       = !reset && (state == HALT);
   assign bus.bus_error    = bus_error_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for the stall sequencer: directed vectors push expected
// controls/counters, a negedge monitor pops and compares.
module tb_pipeline_stall_controller;

   localparam int CNT_W = 32;

   localparam logic [6:0] IDLE  = 7'b0000000;
   localparam logic [6:0] HS    = 7'b1000000;
   localparam logic [6:0] BR    = 7'b0100000;
   localparam logic [6:0] JP    = 7'b0010000;
   localparam logic [6:0] IMISS = 7'b0001000;
   localparam logic [6:0] DREQ  = 7'b0000100;
   localparam logic [6:0] DRDY  = 7'b0000010;
   localparam logic [6:0] HLT   = 7'b0000001;

   // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, mem_wb_write}
   localparam logic [5:0] C_RUN = 6'b110011;
   localparam logic [5:0] C_FRZ = 6'b000000;
   localparam logic [5:0] C_IW  = 6'b001011;
   localparam logic [5:0] C_HZ  = 6'b000111;
   localparam logic [5:0] C_BR  = 6'b111011;
   localparam logic [5:0] C_HQ  = 6'b011011;
   localparam logic [5:0] C_DR  = 6'b011111;

   typedef struct {
      string       name;
      logic [5:0]  ctrl;
      logic        halted;
      logic        bus_err;
      logic [31:0] stall;
      logic [31:0] flush;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       sat_inc;
   logic [1:0] sat_count;
   exp_t       sb_q[$];
   int         checks;
   int         errors;

   pipeline_stall_controller_if #(.CNT_W(CNT_W)) bus ();

   pipeline_stall_controller #(
      .CNT_W        (CNT_W),
      .DRAIN_CYCLES (3),
      .WAIT_TIMEOUT (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   sat_counter #(.CNT_W(2)) u_sat (
      .clk   (clk),
      .reset (reset),
      .inc   (sat_inc),
      .count (sat_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s.%s actual=%0h expected=%0h", name, field, act, exp);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      logic [5:0] act_ctrl;
      act_ctrl = {bus.pc_write, bus.if_id_write, bus.if_id_flush,
                  bus.id_ex_bubble, bus.ex_mem_write, bus.mem_wb_write};
      cmp(e.name, "ctrl", 32'(act_ctrl), 32'(e.ctrl));
      cmp(e.name, "halted", 32'(bus.halted), 32'(e.halted));
      cmp(e.name, "bus_error", 32'(bus.bus_error), 32'(e.bus_err));
      cmp(e.name, "stall_cycles", bus.stall_cycles, e.stall);
      cmp(e.name, "flush_count", bus.flush_count, e.flush);
   endtask

   task automatic applyStimulus(input string name, input logic rst, input logic [6:0] v,
                                input logic [5:0] ctrl, input logic halted, input logic bus_err,
                                input int stall, input int flush);
      exp_t e;
      @(posedge clk);
      #1;
      reset            = rst;
      bus.hazard_stall = v[6];
      bus.branch_taken = v[5];
      bus.jump         = v[4];
      bus.imem_ready   = !v[3];
      bus.dmem_req     = v[2];
      bus.dmem_ready   = v[1];
      bus.halt_req     = v[0];
      e.name    = name;
      e.ctrl    = ctrl;
      e.halted  = halted;
      e.bus_err = bus_err;
      e.stall   = 32'(stall);
      e.flush   = 32'(flush);
      sb_q.push_back(e);
   endtask

   // Monitor: every negedge with a pending expectation compares the DUT.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         checkOutput(sb_q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks           = 0;
      errors           = 0;
      reset            = 1'b1;
      sat_inc          = 1'b0;
      bus.hazard_stall = 1'b0;
      bus.branch_taken = 1'b0;
      bus.jump         = 1'b0;
      bus.imem_ready   = 1'b1;
      bus.dmem_req     = 1'b0;
      bus.dmem_ready   = 1'b0;
      bus.halt_req     = 1'b0;

      applyStimulus("reset",        1, IDLE,            C_FRZ, 0, 0, 0, 0);
      applyStimulus("idle",         0, IDLE,            C_RUN, 0, 0, 0, 0);
      applyStimulus("load_use",     0, HS,              C_HZ,  0, 0, 0, 0);
      applyStimulus("after_lu",     0, IDLE,            C_RUN, 0, 0, 1, 0);
      applyStimulus("hs_over_br",   0, HS | BR,         C_HZ,  0, 0, 1, 0);
      applyStimulus("branch",       0, BR,              C_BR,  0, 0, 2, 0);
      applyStimulus("jump",         0, JP,              C_BR,  0, 0, 2, 1);
      applyStimulus("idle2",        0, IDLE,            C_RUN, 0, 0, 2, 2);
      applyStimulus("imiss",        0, IMISS,           C_IW,  0, 0, 2, 2);
      applyStimulus("iwait",        0, IMISS,           C_IW,  0, 0, 3, 2);
      applyStimulus("iwait_jump",   0, JP,              C_BR,  0, 0, 4, 2);
      applyStimulus("idle3",        0, IDLE,            C_RUN, 0, 0, 4, 3);
      applyStimulus("dwait1",       0, DREQ,            C_FRZ, 0, 0, 4, 3);
      applyStimulus("dwait2",       0, DREQ,            C_FRZ, 0, 0, 5, 3);
      applyStimulus("dwait3",       0, DREQ,            C_FRZ, 0, 0, 6, 3);
      applyStimulus("dwait4",       0, DREQ,            C_FRZ, 0, 0, 7, 3);
      applyStimulus("drelease",     0, DREQ | DRDY,     C_RUN, 0, 0, 8, 3);
      applyStimulus("back_run",     0, IDLE,            C_RUN, 0, 0, 8, 3);
      applyStimulus("imiss2",       0, IMISS,           C_IW,  0, 0, 8, 3);
      applyStimulus("iwait_dmem",   0, IMISS | DREQ,    C_FRZ, 0, 0, 9, 3);
      applyStimulus("drelease2",    0, DREQ | DRDY,     C_RUN, 0, 0, 10, 3);
      applyStimulus("prio_dmem",    0, DREQ | IMISS | HS, C_FRZ, 0, 0, 10, 3);
      applyStimulus("release_hs",   0, DREQ | DRDY | HS, C_RUN, 0, 0, 11, 3);
      applyStimulus("hs_over_halt", 0, HS | HLT,        C_HZ,  0, 0, 11, 3);
      applyStimulus("halt_req",     0, HLT,             C_HQ,  0, 0, 12, 3);
      applyStimulus("drain1",       0, IDLE,            C_DR,  0, 0, 13, 3);
      applyStimulus("drain_dmem",   0, DREQ,            C_FRZ, 0, 0, 13, 3);
      applyStimulus("drain2",       0, IDLE,            C_DR,  0, 0, 13, 3);
      applyStimulus("drain3",       0, IDLE,            C_DR,  0, 0, 13, 3);
      applyStimulus("halted_br",    0, BR,              C_FRZ, 1, 0, 13, 3);
      applyStimulus("halted_idle",  0, IDLE,            C_FRZ, 1, 0, 13, 3);
      applyStimulus("reset2",       1, IDLE,            C_FRZ, 0, 0, 0, 0);
      applyStimulus("run2",         0, IDLE,            C_RUN, 0, 0, 0, 0);
      applyStimulus("to_start",     0, DREQ,            C_FRZ, 0, 0, 0, 0);
      for (int k = 1; k <= 8; k++) begin
         applyStimulus($sformatf("to_wait%0d", k), 0, DREQ, C_FRZ, 0, 0, k, 0);
      end
      applyStimulus("to_halt",      0, DREQ,            C_FRZ, 1, 1, 9, 0);
      applyStimulus("to_sticky",    0, DREQ | DRDY,     C_FRZ, 1, 1, 9, 0);
      applyStimulus("reset3",       1, IDLE,            C_FRZ, 0, 0, 0, 0);
      applyStimulus("run3",         0, IDLE,            C_RUN, 0, 0, 0, 0);
      applyStimulus("dw_a",         0, DREQ,            C_FRZ, 0, 0, 0, 0);
      applyStimulus("dw_b",         0, DREQ,            C_FRZ, 0, 0, 1, 0);
      applyStimulus("reset_in_dw",  1, DREQ,            C_FRZ, 0, 0, 0, 0);
      applyStimulus("run4",         0, IDLE,            C_RUN, 0, 0, 0, 0);

      // Saturation of the perf counter primitive at a narrow width.
      @(posedge clk);
      #1;
      sat_inc = 1'b1;
      @(posedge clk);
      #1;
      cmp("sat", "count_1", 32'(sat_count), 32'd1);
      repeat (4) @(posedge clk);
      #1;
      cmp("sat", "count_sat", 32'(sat_count), 32'd3);
      sat_inc = 1'b0;
      @(posedge clk);
      #1;
      cmp("sat", "count_hold", 32'(sat_count), 32'd3);

      @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain pending=%0d expected=0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
